// File: rtl/window_generator_pkg.sv
// rtl/window_generator_pkg.sv - shared window geometry constants for the window generator and rank filter
package window_generator_pkg;

    // Default geometry shared by the window generator and the downstream rank filter
    localparam int WG_WINDOW_WIDTH = 3;
    localparam int WG_COLOR_WIDTH  = 8;

    // Pixels in one full window (width x height)
    localparam int WG_WINDOW_SIZE  = WG_WINDOW_WIDTH * WG_WINDOW_WIDTH;

    // Bits in the flattened window bus (window generator out_data == rank filter in_data)
    localparam int WG_FLAT_WIDTH   = WG_COLOR_WIDTH * WG_WINDOW_SIZE;

    // Pixels in a window of arbitrary width
    function automatic int window_size(input int ww);
        return ww * ww;
    endfunction

    // Flattened bus width for arbitrary geometry
    function automatic int flat_width(input int cw, input int ww);
        return cw * ww * ww;
    endfunction

endpackage

// File: rtl/window_line_buffer.sv
// rtl/window_line_buffer.sv - single-port read-before-write line RAM, one image line deep
module window_line_buffer #(
    parameter int depth     = 320,
    parameter int width     = 8,
    parameter int addr_bits = 9
) (
    input  logic                 clk,
    input  logic [addr_bits-1:0] addr,
    input  logic                 wr_en,
    input  logic [width-1:0]     din,
    output logic [width-1:0]     dout
);

    // Contents are deliberately not reset; row gating upstream masks stale lines
    logic [width-1:0] mem [depth];

    // Write the new pixel at the shared column address
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= din;
        end
    end

    // Asynchronous read returns the old content during the write cycle
    assign dout = mem[addr];

endmodule

// File: rtl/window_generator.sv
// rtl/window_generator.sv - raster-scan sliding window builder feeding the rank filter
module window_generator
    import window_generator_pkg::*;
#(
    parameter int window_width  = WG_WINDOW_WIDTH,
    parameter int color_width   = WG_COLOR_WIDTH,
    parameter int im_width      = 320,
    parameter int im_width_bits = 9
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              in_enable,
    input  logic [color_width-1:0]                            in_data,
    output logic                                              out_ready,
    output logic [color_width*window_width*window_width-1:0]  out_data
);

    localparam int WSIZE = window_size(window_width);
    localparam int FLAT  = flat_width(color_width, window_width);

    localparam logic [im_width_bits-1:0] COL_LAST        = im_width_bits'(im_width - 1);
    localparam logic [im_width_bits-1:0] COL_FIRST_VALID = im_width_bits'(window_width - 1);
    localparam logic [3:0]               ROW_LAST        = 4'(window_width - 1);

    logic [im_width_bits-1:0] col_q, col_d;
    logic [3:0]               row_q, row_d;
    logic                     rdy_q, rdy_d;
    logic [FLAT-1:0]          win_q, win_d;

    logic [color_width-1:0]   lb_dout [window_width-1];
    logic [color_width-1:0]   col_pix [window_width];

    // Line buffers form a vertical delay chain: buffer 0 holds the previous line,
    // buffer k holds the line k+1 lines back
    for (genvar k = 0; k < window_width - 1; k++) begin : g_lb
        logic [color_width-1:0] lb_din;
        if (k == 0) begin : g_first
            assign lb_din = in_data;
        end else begin : g_rest
            assign lb_din = lb_dout[k-1];
        end
        window_line_buffer #(
            .depth    (im_width),
            .width    (color_width),
            .addr_bits(im_width_bits)
        ) u_lb (
            .clk  (clk),
            .addr (col_q),
            .wr_en(in_enable),
            .din  (lb_din),
            .dout (lb_dout[k])
        );
    end

    // Newest column: oldest row from the deepest buffer, bottom row straight from the input
    for (genvar r = 0; r < window_width; r++) begin : g_col
        if (r == window_width - 1) begin : g_cur
            assign col_pix[r] = in_data;
        end else begin : g_old
            assign col_pix[r] = lb_dout[window_width-2-r];
        end
    end

    // Next-state: advance counters, shift window one column, flag a complete window
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        rdy_d = 1'b0;
        win_d = win_q;
        if (in_enable) begin
            rdy_d = (col_q >= COL_FIRST_VALID) && (row_q == ROW_LAST);
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q != ROW_LAST) begin
                    row_d = row_q + 4'd1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
            for (int r = 0; r < window_width; r++) begin
                for (int c = 0; c < window_width - 1; c++) begin
                    win_d[(r*window_width+c)*color_width +: color_width] =
                        win_q[(r*window_width+c+1)*color_width +: color_width];
                end
                win_d[(r*window_width+window_width-1)*color_width +: color_width] = col_pix[r];
            end
        end
    end

    // State registers; reset clears everything except the line RAM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
            rdy_q <= 1'b0;
            win_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            rdy_q <= rdy_d;
            win_q <= win_d;
        end
    end

    assign out_ready = rdy_q;
    assign out_data  = win_q[color_width*WSIZE-1:0];

endmodule

// File: tb/tb_window_generator.sv
// tb/tb_window_generator.sv - randomized and directed self-checking bench for window_generator
module tb_window_generator;

    localparam int WW  = 3;
    localparam int CW  = 8;
    localparam int IMW = 8;
    localparam int FW  = CW * WW * WW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_enable = 1'b0;
    logic [CW-1:0] in_data = '0;
    logic          out_ready;
    logic [FW-1:0] out_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [CW-1:0] pix [$];
    logic [FW-1:0] exp_win = '0;
    logic          held_ok = 1'b1;
    int            pulses_line [8];

    window_generator #(
        .window_width (WW),
        .color_width  (CW),
        .im_width     (IMW),
        .im_width_bits(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_enable(in_enable),
        .in_data  (in_data),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] pack9(input int v0, input int v1, input int v2,
                                            input int v3, input int v4, input int v5,
                                            input int v6, input int v7, input int v8);
        logic [FW-1:0] w;
        w = '0;
        w[0*CW +: CW] = CW'(v0); w[1*CW +: CW] = CW'(v1); w[2*CW +: CW] = CW'(v2);
        w[3*CW +: CW] = CW'(v3); w[4*CW +: CW] = CW'(v4); w[5*CW +: CW] = CW'(v5);
        w[6*CW +: CW] = CW'(v6); w[7*CW +: CW] = CW'(v7); w[8*CW +: CW] = CW'(v8);
        return w;
    endfunction

    // Window whose newest pixel is stream index n: element (r,c) is the pixel
    // (WW-1-c) positions earlier on the line (WW-1-r) lines above
    function automatic logic [FW-1:0] win_at(input int n);
        logic [FW-1:0] w;
        w = '0;
        for (int r = 0; r < WW; r++) begin
            for (int c = 0; c < WW; c++) begin
                w[(r*WW+c)*CW +: CW] = pix[n - (WW-1-c) - (WW-1-r)*IMW];
            end
        end
        return w;
    endfunction

    task automatic step(input logic en, input logic [CW-1:0] d);
        int  n;
        logic exp_rdy;
        @(negedge clk);
        in_enable = en;
        in_data   = d;
        @(posedge clk);
        if (en) pix.push_back(d);
        #1;
        n = pix.size() - 1;
        exp_rdy = en && (n % IMW) >= WW-1 && (n / IMW) >= WW-1;
        check_eq("ready", FW'(out_ready), FW'(exp_rdy));
        if (out_ready && n >= 0) pulses_line[(n / IMW) % 8]++;
        if (exp_rdy) begin
            exp_win = win_at(n);
            held_ok = 1'b1;
            check_eq("window", out_data, exp_win);
        end else if (!en && held_ok) begin
            check_eq("hold", out_data, exp_win);
        end else if (en) begin
            held_ok = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_enable = 1'b0;
        #1;
        check_eq("rst_ready", FW'(out_ready), '0);
        check_eq("rst_data", out_data, '0);
        pix.delete();
        exp_win = '0;
        held_ok = 1'b1;
        for (int i = 0; i < 8; i++) pulses_line[i] = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1;
        check_eq("init_ready", FW'(out_ready), '0);
        check_eq("init_data", out_data, '0);
        do_reset();

        // Fresh start, line boundary and throughput with a ramp
        for (int v = 0; v < 32; v++) begin
            step(1'b1, CW'(v));
            if (v == 18) check_eq("first_win", out_data, pack9(0,1,2,8,9,10,16,17,18));
            if (v == 24 || v == 25) check_eq("boundary_ready", FW'(out_ready), '0);
            if (v == 26) check_eq("after_boundary", out_data, pack9(8,9,10,16,17,18,24,25,26));
        end
        check_eq("pulses_line0", FW'(pulses_line[0] + pulses_line[1]), '0);
        check_eq("pulses_line2", FW'(pulses_line[2]), FW'(6));
        check_eq("pulses_line3", FW'(pulses_line[3]), FW'(6));

        // Stall after value 20
        do_reset();
        for (int v = 0; v <= 20; v++) step(1'b1, CW'(v));
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'hAA);
            check_eq("stall_data", out_data, pack9(2,3,4,10,11,12,18,19,20));
        end
        step(1'b1, CW'(21));
        check_eq("post_stall", out_data, pack9(3,4,5,11,12,13,19,20,21));

        // Asynchronous reset mid-line, then fresh-start timing again
        do_reset();
        for (int v = 0; v <= 12; v++) step(1'b1, CW'(v));
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_ready", FW'(out_ready), '0);
        check_eq("async_data", out_data, '0);
        do_reset();
        for (int v = 0; v <= 18; v++) begin
            step(1'b1, CW'(v));
            if (v == 17) check_eq("restart_early", FW'(out_ready), '0);
        end
        check_eq("restart_win", out_data, pack9(0,1,2,8,9,10,16,17,18));

        // Random data with random stalls and one reset in the middle
        do_reset();
        for (int i = 0; i < 700; i++) begin
            if (i == 350) do_reset();
            step($urandom_range(0, 3) != 0, CW'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/window_generator.md
WINDOW_GENERATOR -- requirements
Module: window_generator

Interface
REQ-001 The module SHALL have parameter window_width, default 3, giving the window width and height, range 2-15.
REQ-002 The module SHALL have parameter color_width, default 8, giving the pixel bit width, range 1-12.
REQ-003 The module SHALL have parameter im_width, default 320, giving the image line length in pixels, range window_width to 2^im_width_bits.
REQ-004 The module SHALL have parameter im_width_bits, default 9, giving the column counter width.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The module SHALL have port in_enable, input, 1 bit: high means in_data carries a valid raster-order pixel this cycle.
REQ-008 The module SHALL have port in_data, input, color_width bits: the pixel.
REQ-009 The module SHALL have port out_ready, output, 1 bit: high means out_data holds a complete valid window.
REQ-010 The module SHALL have port out_data, output, color_width*window_width*window_width bits: the flattened window, which is the rank filter's in_data.

Function
REQ-011 The module SHALL accept one pixel on every clk edge where in_enable=1; with in_enable=0, all state (counters, line buffers, window registers) SHALL hold.
REQ-012 The module SHALL place window element e=r*window_width+c at out_data[(e+1)*color_width-1 : e*color_width], with row r=0 the oldest line, r=window_width-1 the current line, column c=0 the oldest pixel, and c=window_width-1 the newest pixel.
REQ-013 The module SHALL keep window_width-1 line buffers, each im_width deep, sharing one column address; on each accepted pixel, buffer k SHALL read its old content, then write buffer k-1's old output, with buffer 0 writing in_data.
REQ-014 The module SHALL shift the window register left by one column per accepted pixel, with the new column formed from the line-buffer outputs (rows 0..window_width-2) plus in_data (row window_width-1).
REQ-015 The column counter SHALL increment per accepted pixel and wrap from im_width-1 to 0; on wrap, the row counter SHALL increment and saturate at window_width-1.
REQ-016 The module SHALL register out_ready to 1 in the cycle after an accepted pixel whose pre-increment column is >= window_width-1 and whose row is >= window_width-1; out_ready SHALL be 0 in every other cycle, including stall cycles. out_ready is therefore a one-cycle pulse per valid window.
REQ-017 Latency SHALL be 1 clk from the accepting edge of the window's newest pixel to out_ready=1 with matching out_data.
REQ-018 Windows straddling a line boundary (column < window_width-1) SHALL never assert out_ready.
REQ-019 out_data SHALL hold its last value while out_ready=0; consumers SHALL sample only while out_ready=1.
REQ-020 Once the row counter saturates, the module SHALL stream frames back-to-back; there is no frame-end input, and a new frame requires rst.

Reset
REQ-021 When rst is asserted, the module SHALL immediately clear the column counter, row counter, out_ready, and the window register (out_data=0), without waiting for clk.
REQ-022 Line-buffer RAM contents SHALL NOT be cleared by reset; the row counter gating SHALL prevent stale data from reaching a valid window.
REQ-023 When rst is asserted mid-line, the module SHALL discard partial state; the first out_ready after release SHALL follow exactly the fresh-start timing of REQ-016.

Structure
REQ-024 The module SHALL instantiate one sub-module, window_line_buffer: a single-port read-before-write RAM, im_width x color_width, with addr, wr_en and din inputs and a dout output, instantiated window_width-1 times.
REQ-025 The shared package SHALL hold the full window size constant (window_width*window_width) and the flattened-width constant used by this block and the rank filter.
REQ-026 The implementation SHALL use no combinational path from in_data to out_data.

Verification (window_width=3, im_width=8, color_width=8)
REQ-027 Fresh start: feed pixels with values 0,1,2,... continuously -> first out_ready one cycle after value 18 is accepted; elements 0..8 = 0,1,2,8,9,10,16,17,18.
REQ-028 Line boundary: continue the stream -> out_ready=0 after values 24 and 25; out_ready=1 after 26 with elements = 8,9,10,16,17,18,24,25,26.
REQ-029 Stall: drop in_enable for 5 cycles after value 20 -> out_ready=0 during the stall with out_data unchanged; value 21 then yields window 3,4,5,11,12,13,19,20,21.
REQ-030 Mid-line reset: assert rst after value 12 -> out_ready=0 and out_data=0 asynchronously; restarting from 0 reproduces REQ-027 exactly.
REQ-031 Throughput: continuous 3 lines -> exactly 6 out_ready pulses on line 2 (columns 2-7), and 6 per subsequent line.
REQ-032 Chain to the rank filter (rank=4) with a ramp input -> the median equals the centre element, e.g. 9 for the first window.
